// File: rtl/hwloop_unit.sv
`default_nettype none
// hwloop_unit: hardware-loop start/end/count register file and loop-end redirect controller.
// Optional HWLP_ITER_COUNT_EN adds hwlp_iter_o, a saturating count of cycles with hwlp_jump_o=1.
module hwloop_unit #(
    parameter int N_LOOPS = 2,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 csr_we_i,
    input  logic                       csr_regid_i,
    input  logic [31:0]                csr_data_i,
    input  logic [2:0]                 ins_we_i,
    input  logic                       ins_regid_i,
    input  logic [31:0]                ins_start_i,
    input  logic [31:0]                ins_end_i,
    input  logic [CNT_W-1:0]           ins_cnt_i,
    input  logic [31:0]                pc_id_i,
    input  logic                       id_valid_i,
    output logic [32*N_LOOPS-1:0]      hwlp_start_o,
    output logic [32*N_LOOPS-1:0]      hwlp_end_o,
    output logic [CNT_W*N_LOOPS-1:0]   hwlp_cnt_o,
    output logic                       hwlp_jump_o,
    output logic [31:0]                hwlp_target_o,
    output logic                       hwlp_dec_o
`ifdef HWLP_ITER_COUNT_EN
    ,
    output logic [31:0]                hwlp_iter_o
`endif
);

    localparam int SEL_W = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1;

    logic [31:0]      start_q [N_LOOPS];
    logic [31:0]      end_q   [N_LOOPS];
    logic [CNT_W-1:0] cnt_q   [N_LOOPS];

    logic [N_LOOPS-1:0] match;
    logic [N_LOOPS-1:0] cnt_wr;
    logic               any_match;
    logic [SEL_W-1:0]   sel;
    logic [CNT_W-1:0]   csr_cnt;

    assign csr_cnt = csr_data_i[CNT_W-1:0];

    always_comb begin
        match     = '0;
        cnt_wr    = '0;
        any_match = 1'b0;
        sel       = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            match[i]  = id_valid_i && (pc_id_i == end_q[i]) && (cnt_q[i] != '0);
            cnt_wr[i] = (ins_we_i[2] && (ins_regid_i == 1'(i))) ||
                        (csr_we_i[2] && (csr_regid_i == 1'(i)));
        end
        // Scan downward so the lowest (innermost) matching loop ends up selected.
        for (int i = N_LOOPS - 1; i >= 0; i--) begin
            if (match[i]) begin
                any_match = 1'b1;
                sel       = SEL_W'(i);
            end
        end
    end

    // Jump is decided on the pre-write count; a same-cycle count write drops the decrement.
    assign hwlp_jump_o   = any_match && (cnt_q[sel] > CNT_W'(1));
    assign hwlp_target_o = hwlp_jump_o ? start_q[sel] : 32'h0;
    assign hwlp_dec_o    = any_match && !cnt_wr[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LOOPS; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_LOOPS; i++) begin
                if (ins_we_i[0] && (ins_regid_i == 1'(i)))
                    start_q[i] <= ins_start_i & ~32'h1;
                else if (csr_we_i[0] && (csr_regid_i == 1'(i)))
                    start_q[i] <= csr_data_i & ~32'h1;

                if (ins_we_i[1] && (ins_regid_i == 1'(i)))
                    end_q[i] <= ins_end_i & ~32'h1;
                else if (csr_we_i[1] && (csr_regid_i == 1'(i)))
                    end_q[i] <= csr_data_i & ~32'h1;

                if (ins_we_i[2] && (ins_regid_i == 1'(i)))
                    cnt_q[i] <= ins_cnt_i;
                else if (csr_we_i[2] && (csr_regid_i == 1'(i)))
                    cnt_q[i] <= csr_cnt;
                else if (any_match && (sel == SEL_W'(i)))
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < N_LOOPS; g++) begin : g_flat
            assign hwlp_start_o[32*g +: 32]      = start_q[g];
            assign hwlp_end_o[32*g +: 32]        = end_q[g];
            assign hwlp_cnt_o[CNT_W*g +: CNT_W]  = cnt_q[g];
        end
    endgenerate

`ifdef HWLP_ITER_COUNT_EN
    logic [31:0] iter_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            iter_q <= '0;
        else if (ins_we_i[2])
            iter_q <= '0;
        else if (hwlp_jump_o && (iter_q != 32'hFFFF_FFFF))
            iter_q <= iter_q + 32'd1;
    end

    assign hwlp_iter_o = iter_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hwloop_unit.sv
`default_nettype none
// Self-checking bench for hwloop_unit: per-scenario tasks with a scoreboard of per-cycle expectations.
module tb_hwloop_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  csr_we_i = '0;
    logic        csr_regid_i = 1'b0;
    logic [31:0] csr_data_i = '0;
    logic [2:0]  ins_we_i = '0;
    logic        ins_regid_i = 1'b0;
    logic [31:0] ins_start_i = '0;
    logic [31:0] ins_end_i = '0;
    logic [31:0] ins_cnt_i = '0;
    logic [31:0] pc_id_i = '0;
    logic        id_valid_i = 1'b0;
    logic [63:0] hwlp_start_o;
    logic [63:0] hwlp_end_o;
    logic [63:0] hwlp_cnt_o;
    logic        hwlp_jump_o;
    logic [31:0] hwlp_target_o;
    logic        hwlp_dec_o;
`ifdef HWLP_ITER_COUNT_EN
    logic [31:0] hwlp_iter_o;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        jump;
        logic [31:0] target;
        logic        dec;
        logic [31:0] cnt0;
        logic [31:0] cnt1;
    } exp_t;
    exp_t sb[$];

    hwloop_unit #(.N_LOOPS(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_we_i(csr_we_i), .csr_regid_i(csr_regid_i), .csr_data_i(csr_data_i),
        .ins_we_i(ins_we_i), .ins_regid_i(ins_regid_i), .ins_start_i(ins_start_i),
        .ins_end_i(ins_end_i), .ins_cnt_i(ins_cnt_i),
        .pc_id_i(pc_id_i), .id_valid_i(id_valid_i),
        .hwlp_start_o(hwlp_start_o), .hwlp_end_o(hwlp_end_o), .hwlp_cnt_o(hwlp_cnt_o),
        .hwlp_jump_o(hwlp_jump_o), .hwlp_target_o(hwlp_target_o), .hwlp_dec_o(hwlp_dec_o)
`ifdef HWLP_ITER_COUNT_EN
        , .hwlp_iter_o(hwlp_iter_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins_wr(input logic [2:0] we, input logic id, input logic [31:0] s,
                          input logic [31:0] e, input logic [31:0] c);
        ins_we_i = we; ins_regid_i = id; ins_start_i = s; ins_end_i = e; ins_cnt_i = c;
        tick();
        ins_we_i = '0;
    endtask

    task automatic csr_wr(input logic [2:0] we, input logic id, input logic [31:0] d);
        csr_we_i = we; csr_regid_i = id; csr_data_i = d;
        tick();
        csr_we_i = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (hwlp_start_o !== 64'h0 || hwlp_end_o !== 64'h0 || hwlp_cnt_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_regs start=%h end=%h cnt=%h expected all 0", hwlp_start_o, hwlp_end_o, hwlp_cnt_o);
        end
        checks++;
        if (hwlp_jump_o !== 1'b0 || hwlp_target_o !== 32'h0 || hwlp_dec_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl jump=%b target=%h dec=%b expected 0/0/0", hwlp_jump_o, hwlp_target_o, hwlp_dec_o);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        exp_t e;
        ins_wr(3'b111, 1'b0, 32'h100, 32'h10C, 32'd3);
        checks++;
        if (hwlp_start_o[31:0] !== 32'h100 || hwlp_end_o[31:0] !== 32'h10C || hwlp_cnt_o[31:0] !== 32'd3) begin
            errors++;
            $display("FAIL basic_setup start=%h end=%h cnt=%0d expected 100/10c/3",
                     hwlp_start_o[31:0], hwlp_end_o[31:0], hwlp_cnt_o[31:0]);
        end
        sb.push_back('{1'b1, 32'h100, 1'b1, 32'd2, 32'd0});
        sb.push_back('{1'b1, 32'h100, 1'b1, 32'd1, 32'd0});
        sb.push_back('{1'b0, 32'h0,   1'b1, 32'd0, 32'd0});
        sb.push_back('{1'b0, 32'h0,   1'b0, 32'd0, 32'd0});
        pc_id_i = 32'h10C; id_valid_i = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (hwlp_jump_o !== e.jump || hwlp_target_o !== e.target || hwlp_dec_o !== e.dec) begin
                errors++;
                $display("FAIL basic_ctl jump=%b target=%h dec=%b expected %b/%h/%b",
                         hwlp_jump_o, hwlp_target_o, hwlp_dec_o, e.jump, e.target, e.dec);
            end
            tick();
            checks++;
            if (hwlp_cnt_o[31:0] !== e.cnt0) begin
                errors++;
                $display("FAIL basic_cnt cnt0=%0d expected %0d", hwlp_cnt_o[31:0], e.cnt0);
            end
        end
        id_valid_i = 1'b0;
`ifdef HWLP_ITER_COUNT_EN
        checks++;
        if (hwlp_iter_o !== 32'd2) begin
            errors++;
            $display("FAIL basic_iter iter=%0d expected 2", hwlp_iter_o);
        end
`endif
    endtask

    task automatic test_stall();
        ins_wr(3'b100, 1'b0, 32'h0, 32'h0, 32'd3);
        pc_id_i = 32'h10C; id_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (hwlp_jump_o !== 1'b0 || hwlp_dec_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_ctl cycle=%0d jump=%b dec=%b expected 0/0", k, hwlp_jump_o, hwlp_dec_o);
            end
            tick();
        end
        checks++;
        if (hwlp_cnt_o[31:0] !== 32'd3) begin
            errors++;
            $display("FAIL stall_cnt cnt0=%0d expected 3", hwlp_cnt_o[31:0]);
        end
    endtask

    task automatic test_nested();
        exp_t e;
        ins_wr(3'b111, 1'b0, 32'h1F0, 32'h200, 32'd2);
        ins_wr(3'b111, 1'b1, 32'h1E0, 32'h200, 32'd2);
        sb.push_back('{1'b1, 32'h1F0, 1'b1, 32'd1, 32'd2});
        sb.push_back('{1'b0, 32'h0,   1'b1, 32'd0, 32'd2});
        sb.push_back('{1'b1, 32'h1E0, 1'b1, 32'd0, 32'd1});
        sb.push_back('{1'b0, 32'h0,   1'b1, 32'd0, 32'd0});
        sb.push_back('{1'b0, 32'h0,   1'b0, 32'd0, 32'd0});
        pc_id_i = 32'h200; id_valid_i = 1'b1;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (hwlp_jump_o !== e.jump || hwlp_target_o !== e.target || hwlp_dec_o !== e.dec) begin
                errors++;
                $display("FAIL nested_ctl jump=%b target=%h dec=%b expected %b/%h/%b",
                         hwlp_jump_o, hwlp_target_o, hwlp_dec_o, e.jump, e.target, e.dec);
            end
            tick();
            checks++;
            if (hwlp_cnt_o[31:0] !== e.cnt0 || hwlp_cnt_o[63:32] !== e.cnt1) begin
                errors++;
                $display("FAIL nested_cnt cnt0=%0d cnt1=%0d expected %0d/%0d",
                         hwlp_cnt_o[31:0], hwlp_cnt_o[63:32], e.cnt0, e.cnt1);
            end
        end
        id_valid_i = 1'b0;
    endtask

    task automatic test_write_conflict();
        // Same field, same set: ID wins.
        csr_we_i = 3'b100; csr_regid_i = 1'b1; csr_data_i = 32'd5;
        ins_wr(3'b100, 1'b1, 32'h0, 32'h0, 32'd9);
        csr_we_i = '0;
        checks++;
        if (hwlp_cnt_o[63:32] !== 32'd9) begin
            errors++;
            $display("FAIL conflict_cnt cnt1=%0d expected 9", hwlp_cnt_o[63:32]);
        end
        // Same field, different sets: both apply, bit0 cleared.
        csr_we_i = 3'b001; csr_regid_i = 1'b0; csr_data_i = 32'h301;
        ins_wr(3'b001, 1'b1, 32'h503, 32'h0, 32'd0);
        csr_we_i = '0;
        checks++;
        if (hwlp_start_o[31:0] !== 32'h300 || hwlp_start_o[63:32] !== 32'h502) begin
            errors++;
            $display("FAIL conflict_start start0=%h start1=%h expected 300/502", hwlp_start_o[31:0], hwlp_start_o[63:32]);
        end
        csr_we_i = 3'b010; csr_regid_i = 1'b0; csr_data_i = 32'h401;
        ins_wr(3'b010, 1'b0, 32'h0, 32'h601, 32'd0);
        csr_we_i = '0;
        checks++;
        if (hwlp_end_o[31:0] !== 32'h600) begin
            errors++;
            $display("FAIL conflict_end end0=%h expected 600", hwlp_end_o[31:0]);
        end
    endtask

    task automatic test_write_vs_dec();
        exp_t e;
        ins_wr(3'b111, 1'b0, 32'h700, 32'h70C, 32'd4);
        sb.push_back('{1'b1, 32'h700, 1'b0, 32'd10, 32'd9});
        pc_id_i = 32'h70C; id_valid_i = 1'b1;
        csr_we_i = 3'b100; csr_regid_i = 1'b0; csr_data_i = 32'd10;
        ins_we_i = 3'b001; ins_regid_i = 1'b0; ins_start_i = 32'h800;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (hwlp_jump_o !== e.jump || hwlp_target_o !== e.target) begin
            errors++;
            $display("FAIL wvd_ctl jump=%b target=%h expected %b/%h", hwlp_jump_o, hwlp_target_o, e.jump, e.target);
        end
        tick();
        csr_we_i = '0; ins_we_i = '0; id_valid_i = 1'b0;
        checks++;
        if (hwlp_cnt_o[31:0] !== e.cnt0 || hwlp_cnt_o[63:32] !== e.cnt1 || hwlp_start_o[31:0] !== 32'h800) begin
            errors++;
            $display("FAIL wvd_regs cnt0=%0d cnt1=%0d start0=%h expected %0d/%0d/800",
                     hwlp_cnt_o[31:0], hwlp_cnt_o[63:32], hwlp_start_o[31:0], e.cnt0, e.cnt1);
        end
    endtask

    task automatic test_reset_mid();
        ins_wr(3'b111, 1'b0, 32'h900, 32'h90C, 32'd2);
        pc_id_i = 32'h90C; id_valid_i = 1'b1;
        #1;
        checks++;
        if (hwlp_jump_o !== 1'b1 || hwlp_target_o !== 32'h900) begin
            errors++;
            $display("FAIL rstmid_pre jump=%b target=%h expected 1/900", hwlp_jump_o, hwlp_target_o);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (hwlp_start_o !== 64'h0 || hwlp_end_o !== 64'h0 || hwlp_cnt_o !== 64'h0 ||
            hwlp_jump_o !== 1'b0 || hwlp_target_o !== 32'h0 || hwlp_dec_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async start=%h end=%h cnt=%h jump=%b target=%h dec=%b expected all 0",
                     hwlp_start_o, hwlp_end_o, hwlp_cnt_o, hwlp_jump_o, hwlp_target_o, hwlp_dec_o);
        end
`ifdef HWLP_ITER_COUNT_EN
        checks++;
        if (hwlp_iter_o !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_iter iter=%0d expected 0", hwlp_iter_o);
        end
`endif
        @(negedge clk) rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (hwlp_jump_o !== 1'b0 || hwlp_dec_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post jump=%b dec=%b expected 0/0", hwlp_jump_o, hwlp_dec_o);
        end
        tick();
        id_valid_i = 1'b0;
        checks++;
        if (hwlp_cnt_o !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_cnt cnt=%h expected 0", hwlp_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_nested();
        test_write_conflict();
        test_write_vs_dec();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hwloop_unit.md
Name: hwloop_unit

Overview:
- Hardware-loop register file and loop-end controller for the RI5CY-class core.
- Holds start, end and count for N_LOOPS zero-overhead loops.
- Written by the CSR block's hwlp write strobes, or by the ID stage for lp.setup/lp.start/lp.end/lp.count.
- Feeds start/end/count back to the CSR read mux; drives the fetch-redirect request when the retiring PC hits a loop end.

Parameters:
- N_LOOPS, 2, number of loop register sets; regid width is 1 bit, so max 2.
- CNT_W, 32, loop counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- csr_we_i  in  3  CSR write strobe, one-hot: [0] start, [1] end, [2] count
- csr_regid_i  in  1  loop set targeted by the CSR write
- csr_data_i  in  32  CSR write data
- ins_we_i  in  3  ID-stage write strobe, same encoding as csr_we_i
- ins_regid_i  in  1  loop set targeted by the ID-stage write
- ins_start_i  in  32  start address from the ID stage
- ins_end_i  in  32  end address from the ID stage
- ins_cnt_i  in  CNT_W  iteration count from the ID stage
- pc_id_i  in  32  PC of the instruction in ID
- id_valid_i  in  1  instruction in ID retires this cycle
- hwlp_start_o  out  32*N_LOOPS  start registers, flattened, loop i at [32i+31:32i]
- hwlp_end_o  out  32*N_LOOPS  end registers, flattened
- hwlp_cnt_o  out  CNT_W*N_LOOPS  count registers, flattened
- hwlp_jump_o  out  1  redirect fetch to hwlp_target_o (combinational)
- hwlp_target_o  out  32  redirect target
- hwlp_dec_o  out  1  pulse: a counter decremented this cycle

Behaviour:
- Reset: all start, end and count registers = 0; hwlp_jump_o=0; hwlp_target_o=0; hwlp_dec_o=0.
- Writes
  - Start/end registers store data with bit0 forced to 0.
  - Writes take effect at the next clk edge; outputs show the new value one cycle after the strobe.
  - Same field of the same set written by CSR and ID in one cycle: the ID write wins.
  - Different fields or different sets written in one cycle: all writes apply.
- Match
  - match[i] = id_valid_i & (pc_id_i == end_q[i]) & (cnt_q[i] != 0).
  - sel = lowest i with match[i]; loop 0 is innermost and has priority.
  - Only the selected set is affected.
- Jump
  - hwlp_jump_o = match[sel] & (cnt_q[sel] > 1).
  - hwlp_target_o = start_q[sel] when hwlp_jump_o=1, else 0.
  - Purely combinational from the current-cycle inputs and registers.
- Decrement
  - On match[sel]: cnt[sel] <= cnt[sel] - 1 and hwlp_dec_o=1.
  - cnt reaching 0 deactivates the loop: fall-through, no further matches.
  - A counter at 0 never decrements and never wraps.
- Stalls: id_valid_i=0 means no match, jump or decrement, whatever pc_id_i is.
- Simultaneous write and decrement to the same set's count: the write wins and the decrement is dropped. hwlp_jump_o still follows the pre-write count that cycle.
- Writes to start or end in the same cycle as a match: the match uses the old values; the new values apply next cycle.
- Reset mid-loop: all registers clear asynchronously; no jump is issued after reset deasserts until counts are rewritten.
- No state machine beyond the per-loop active/inactive status implied by cnt != 0.

Optional Feature:
- Macro HWLP_ITER_COUNT_EN.
- When defined, adds output hwlp_iter_o (32 bits) and a register counting cycles with hwlp_jump_o=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared to 0 on reset and on any ins_we_i[2] write.
  - Intended for an external perf-counter input.
- When undefined, the port and register do not exist; all other behaviour is identical.

Test Plan:
- Basic loop: ID write set0 start=0x100, end=0x10C, cnt=3; retire pc 0x10C three times -> jump=1 target=0x100 twice, then jump=0 on the third; cnt_o goes 3,2,1,0; dec pulses three times.
- Stall: pc_id_i=0x10C held with id_valid_i=0 for 5 cycles -> no jump, cnt unchanged at 3.
- Nested, same end: set0 end=set1 end=0x200, cnt0=2, cnt1=2 -> only loop0 decrements and jumps; loop1 unchanged until cnt0=0, then loop1 jumps to start1.
- Write conflict: CSR writes cnt set1=5 and ID writes cnt set1=9 in the same cycle -> cnt1=9. CSR writes start=0x301 -> start_o=0x300.
- Write vs decrement: cnt0=4 matching while CSR writes cnt0=10 -> jump=1 that cycle, cnt0=10 next cycle (not 9 or 3).
- Async reset asserted mid-loop with cnt0=2 -> all outputs 0 immediately; retire pc==old end after release -> no jump. With HWLP_ITER_COUNT_EN, iter_o=0.
